uart_receiver: RTL and testbench

- 8N1 UART receiver: deserialises an asynchronous serial line into bytes and pulses a one-cycle done strobe per good frame.
- Counterpart of uart_transmitter; same bit timing, LSB first, idle-high line.
- Sits between the board RX pin and the byte-consuming logic. Loopback-testable against uart_transmitter.

---
 rtl/uart_receiver_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_receiver.sv | 159 +++++++++++++++
 tb/tb_uart_receiver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: state encoding, frame
// geometry and the default bit period used by both ends of the link.
package uart_receiver_pkg;

  // Data bits per 8N1 frame.
  localparam int UART_DATA_BITS = 8;

  // Default clk cycles per serial bit; uart_transmitter uses the same value.
  localparam int UART_CLKS_PER_BIT = 87;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx pin. Resets to 1 so an
// idle-high line never looks like a start bit right after reset.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw input one stage deeper every cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Synchroniser flop chain, preset to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling of a synchronised rx line, LSB first,
// one-cycle rx_done per good frame and one-cycle frame_err on a low stop bit.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_IDX = 3'(UART_DATA_BITS - 1);

  logic rs;

  uart_rx_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     byte_q, byte_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rs)
  );

  // Next-state, counter, shift-register and strobe logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = 3'd0;
        if (!rs) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          // Still low at mid-start: real start bit; otherwise a glitch.
          if (!rs) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rs;
          if (idx_q == LAST_IDX) begin
            idx_d   = 3'd0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          // Leaving at mid-stop gives half a bit of slack for a
          // back-to-back start edge.
          if (rs) begin
            byte_d  = shift_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        // A held-low line must go high before another start is accepted.
        if (rs) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = 3'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, counters, data and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      byte_q  <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_byte   = byte_q;
  assign rx_done   = done_q;
  assign frame_err = err_q;
  assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random
// frames, checked against an expected-event queue built from the frames sent.
module tb_uart_receiver;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
  localparam int HALF = (CPB - 1) / 2;
  // Cycles from the first clock that sees the start edge to rx_done.
  localparam int NOM  = 9 * CPB + HALF + SYNC + 1;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_byte;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         start;
    bit         is_err;
    logic [7:0] b;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_last;
  int         n_done = 0;
  int         n_err  = 0;

  uart_receiver #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .rx_done  (rx_done),
    .rx_busy  (rx_busy),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare process: every cycle out of reset, match strobes to expectations.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_last = 8'h00;
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && cyc > exp_q[0].start + NOM + 1) begin
        checks++;
        errors++;
        $display("FAIL missing_strobe: timed out waiting for %s at latency %0d", exp_q[0].is_err ? "frame_err" : "rx_done", NOM);
        void'(exp_q.pop_front());
      end
      if (rx_done || frame_err) begin
        chk("exclusive_strobes", {31'd0, rx_done & frame_err}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: done=%0b err=%0b with nothing expected", rx_done, frame_err);
        end else begin
          exp_t e;
          int   lat;
          e   = exp_q.pop_front();
          lat = cyc - e.start;
          checks++;
          if (lat < NOM - 1 || lat > NOM + 1) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d +/-1", lat, NOM);
          end
          chk("strobe_kind_done", {31'd0, rx_done}, {31'd0, ~e.is_err});
          if (!e.is_err) begin
            model_last = e.b;
            n_done++;
          end else begin
            n_err++;
          end
        end
      end
      chk("rx_byte", {24'd0, rx_byte}, {24'd0, model_last});
    end
  end

  // Hold the current line level for n clocks; driver stays at posedge+1.
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int extra_low);
    exp_t e;
    rx       = 1'b0;
    e.start  = cyc + 1;
    e.is_err = ~stop_bit;
    e.b      = b;
    exp_q.push_back(e);
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(CPB);
    end
    rx = stop_bit;
    hold(CPB + extra_low);
    rx = 1'b1;
  endtask

  task automatic wait_quiet();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 20 * CPB) begin
      hold(1);
      k++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL wait_quiet: %0d expectations still pending", exp_q.size());
    end
    hold(2);
  endtask

  initial begin
    int exp_done;
    int exp_err;
    logic [7:0] rb;
    rst_n = 1'b0;
    rx    = 1'b1;
    exp_done = 0;
    exp_err  = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_byte", {24'd0, rx_byte}, 32'h00);
    chk("reset_done", {31'd0, rx_done}, 32'd0);
    chk("reset_err",  {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, rx_busy}, 32'd0);
    rst_n = 1'b1;

    // Idle line for 1000 cycles.
    hold(1000);
    chk("idle_busy", {31'd0, rx_busy}, 32'd0);
    chk("idle_byte", {24'd0, rx_byte}, 32'h00);

    // Single frame 8'h41, with a busy check mid-frame.
    fork
      send_frame(8'h41, 1'b1, 0);
      begin
        hold(3 * CPB);
        chk("busy_mid_frame", {31'd0, rx_busy}, 32'd1);
      end
    join
    exp_done++;
    wait_quiet();
    chk("byte_41", {24'd0, rx_byte}, 32'h41);
    hold(CPB);
    chk("busy_after_41", {31'd0, rx_busy}, 32'd0);

    // Back-to-back frames, no idle gap.
    send_frame(8'h55, 1'b1, 0);
    send_frame(8'hA3, 1'b1, 0);
    exp_done += 2;
    wait_quiet();
    chk("byte_a3", {24'd0, rx_byte}, 32'hA3);

    // Glitch shorter than half a bit.
    rx = 1'b0;
    hold(CPB / 4);
    rx = 1'b1;
    hold(3 * CPB);
    chk("glitch_busy", {31'd0, rx_busy}, 32'd0);
    chk("glitch_byte", {24'd0, rx_byte}, 32'hA3);

    // Framing error: stop bit low, line low 3 bit-times total, then high.
    send_frame(8'hFF, 1'b0, 2 * CPB);
    exp_err++;
    wait_quiet();
    hold(2 * CPB);
    chk("ferr_byte_kept", {24'd0, rx_byte}, 32'hA3);
    chk("ferr_busy", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h0F, 1'b1, 0);
    exp_done++;
    wait_quiet();
    chk("byte_0f", {24'd0, rx_byte}, 32'h0F);

    // Reset during data bit 4 of 8'h3C.
    rb = 8'h3C;
    rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = rb[i];
      hold(CPB);
    end
    rx = rb[4];
    hold(CPB / 2);
    rst_n = 1'b0;
    rx    = 1'b1;
    hold(3);
    chk("midreset_byte", {24'd0, rx_byte}, 32'h00);
    chk("midreset_busy", {31'd0, rx_busy}, 32'd0);
    rst_n = 1'b1;
    hold(2 * CPB);
    chk("post_reset_busy", {31'd0, rx_busy}, 32'd0);
    send_frame(8'hC3, 1'b1, 0);
    exp_done++;
    wait_quiet();
    chk("byte_c3", {24'd0, rx_byte}, 32'hC3);

    // Random frames with random idle gaps (including none).
    for (int n = 0; n < 24; n++) begin
      logic [7:0] rbyte;
      int gap;
      rbyte = 8'($urandom_range(0, 255));
      gap   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 2 * CPB);
      send_frame(rbyte, 1'b1, 0);
      exp_done++;
      if (gap > 0) hold(gap);
    end
    wait_quiet();

    chk("total_done", n_done, exp_done);
    chk("total_err",  n_err,  exp_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
